// File: rtl/jal_execute_pkg.sv
// Shared constants for the jal/jalr execute path: widths, the packed layout of
// the issue bundle, and the PC increments for compressed and normal encodings.
package jal_execute_pkg;
    localparam int RNBIT  = 2;
    localparam int DW     = 64;
    localparam int PIDX_W = 5 + RNBIT;
    localparam int INFO_W = 2 + PIDX_W + 3*DW + 1;

    // Field positions in jal_execute_info, LSB upward.
    localparam int INFO_RVC_BIT  = 0;
    localparam int INFO_IMM_LSB  = 1;
    localparam int INFO_PC_LSB   = INFO_IMM_LSB + DW;
    localparam int INFO_SRC1_LSB = INFO_PC_LSB + DW;
    localparam int INFO_RD0_LSB  = INFO_SRC1_LSB + DW;
    localparam int INFO_JALR_BIT = INFO_RD0_LSB + PIDX_W;
    localparam int INFO_JAL_BIT  = INFO_JALR_BIT + 1;

    localparam logic [DW-1:0] PC_INC_RVC = 64'd2;
    localparam logic [DW-1:0] PC_INC_STD = 64'd4;
endpackage

// File: rtl/jal_execute_pipe_skid.sv
// Two-entry valid/ready register (output stage plus one skid entry). Upstream
// ready depends only on local state and flush, never on downstream ready.
module jal_execute_pipe_skid #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;
    logic         drain;

    assign in_ready  = ~skid_valid_q & ~flush;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (drain) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        // Flush drops both entries; data is left as-is since valid gates it.
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/jal_execute.sv
// Execute stage for jal/jalr: computes the link value toward writeback and,
// for jalr, a one-cycle redirect carrying the resolved target back to fetch.
module jal_execute
    import jal_execute_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              jal_execute_vaild,
    output logic              jal_execute_ready,
    input  logic [INFO_W-1:0] jal_execute_info,
    output logic              jal_writeback_vaild,
    input  logic              jal_writeback_ready,
    output logic [DW-1:0]     jal_res,
    output logic [PIDX_W-1:0] jal_rd0,
    output logic              jalr_redirect_vaild,
    output logic [DW-1:0]     jalr_redirect_pc,
    input  logic              flush
);
    logic              jalr_op;
    logic              jal_op_unused;
    logic              is_rvc;
    logic [PIDX_W-1:0] rd0;
    logic [DW-1:0]     src1, pc, imm;
    logic [DW-1:0]     link, target;
    logic              accept;
    logic              redir_valid_q, redir_valid_d;
    logic [DW-1:0]     redir_pc_q, redir_pc_d;

    // jal targets are resolved in fetch, so the jal flag has no consumer here.
    assign jal_op_unused = jal_execute_info[INFO_JAL_BIT];
    assign jalr_op       = jal_execute_info[INFO_JALR_BIT];
    assign rd0           = jal_execute_info[INFO_RD0_LSB +: PIDX_W];
    assign src1          = jal_execute_info[INFO_SRC1_LSB +: DW];
    assign pc            = jal_execute_info[INFO_PC_LSB +: DW];
    assign imm           = jal_execute_info[INFO_IMM_LSB +: DW];
    assign is_rvc        = jal_execute_info[INFO_RVC_BIT];

    assign link   = pc + (is_rvc ? PC_INC_RVC : PC_INC_STD);
    assign target = (src1 + imm) & ~{{(DW-1){1'b0}}, 1'b1};
    assign accept = jal_execute_vaild & jal_execute_ready;

    jal_execute_pipe_skid #(
        .W (PIDX_W + DW)
    ) u_pipe_skid (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .flush     (flush),
        .in_valid  (jal_execute_vaild),
        .in_ready  (jal_execute_ready),
        .in_data   ({rd0, link}),
        .out_valid (jal_writeback_vaild),
        .out_ready (jal_writeback_ready),
        .out_data  ({jal_rd0, jal_res})
    );

    always_comb begin
        redir_valid_d = accept & jalr_op & ~flush;
        redir_pc_d    = redir_pc_q;
        if (accept && jalr_op) begin
            redir_pc_d = target;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign jalr_redirect_vaild = redir_valid_q;
    assign jalr_redirect_pc    = redir_pc_q;
endmodule

// File: tb/tb_jal_execute.sv
// Scoreboard bench for jal_execute: expected writebacks and redirects are queued
// at accept time and compared by a monitor when the DUT presents them.
module tb_jal_execute;
    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         jal_execute_vaild = 1'b0;
    logic         jal_execute_ready;
    logic [201:0] jal_execute_info = '0;
    logic         jal_writeback_vaild;
    logic         jal_writeback_ready = 1'b1;
    logic [63:0]  jal_res;
    logic [6:0]   jal_rd0;
    logic         jalr_redirect_vaild;
    logic [63:0]  jalr_redirect_pc;
    logic         flush = 1'b0;

    always #5 CLK = ~CLK;

    jal_execute dut (
        .CLK                 (CLK),
        .RSTn                (RSTn),
        .jal_execute_vaild   (jal_execute_vaild),
        .jal_execute_ready   (jal_execute_ready),
        .jal_execute_info    (jal_execute_info),
        .jal_writeback_vaild (jal_writeback_vaild),
        .jal_writeback_ready (jal_writeback_ready),
        .jal_res             (jal_res),
        .jal_rd0             (jal_rd0),
        .jalr_redirect_vaild (jalr_redirect_vaild),
        .jalr_redirect_pc    (jalr_redirect_pc),
        .flush               (flush)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]  rd;
        logic [63:0] link;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [63:0] rd_q[$];
    wb_exp_t     mon_e;
    logic [63:0] mon_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn) begin
            if (jal_writeback_vaild && jal_writeback_ready) begin
                if (wb_q.size() == 0) begin
                    chk("wb_spurious", 64'd1, 64'd0);
                end else begin
                    mon_e = wb_q.pop_front();
                    $display("WB rd0=%0d res=0x%h", jal_rd0, jal_res);
                    chk("wb_res", jal_res, mon_e.link);
                    chk("wb_rd0", {57'd0, jal_rd0}, {57'd0, mon_e.rd});
                end
            end
            if (jalr_redirect_vaild) begin
                if (rd_q.size() == 0) begin
                    chk("redir_spurious", 64'd1, 64'd0);
                end else begin
                    mon_pc = rd_q.pop_front();
                    $display("REDIRECT pc=0x%h", jalr_redirect_pc);
                    chk("redir_pc", jalr_redirect_pc, mon_pc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic jal, input logic jalr, input logic [6:0] rd,
                         input logic [63:0] s1, input logic [63:0] pc,
                         input logic [63:0] imm, input logic rvc);
        logic    got;
        wb_exp_t e;
        got = 1'b0;
        jal_execute_info  = {jal, jalr, rd, s1, pc, imm, rvc};
        jal_execute_vaild = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge CLK);
            got = jal_execute_ready;
            @(posedge CLK);
        end
        #1;
        jal_execute_vaild = 1'b0;
        if (!got) begin
            chk("issue_timeout", 64'd1, 64'd0);
        end else begin
            e.rd   = rd;
            e.link = pc + (rvc ? 64'd2 : 64'd4);
            wb_q.push_back(e);
            if (jalr) rd_q.push_back((s1 + imm) & ~64'd1);
            $display("ISSUE jal=%0b jalr=%0b rd0=%0d pc=0x%h rvc=%0b", jal, jalr, rd, pc, rvc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wbv"}, {63'd0, jal_writeback_vaild}, 64'd0);
        chk({tag, "_rdv"}, {63'd0, jalr_redirect_vaild}, 64'd0);
        chk({tag, "_res"}, jal_res, 64'd0);
        chk({tag, "_rd0"}, {57'd0, jal_rd0}, 64'd0);
        chk({tag, "_rpc"}, jalr_redirect_pc, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst");
        chk("rst_ready", {63'd0, jal_execute_ready}, 64'd1);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        idle(1);

        // Single jal
        issue(1'b1, 1'b0, 7'd1, 64'd0, 64'h8000_0000, 64'd0, 1'b0);
        @(negedge CLK);
        chk("jal_lat_valid", {63'd0, jal_writeback_vaild}, 64'd1);
        chk("jal_no_redir", {63'd0, jalr_redirect_vaild}, 64'd0);
        idle(2);

        // Compressed jalr
        issue(1'b0, 1'b1, 7'd5, 64'h2001, 64'h1000, 64'h10, 1'b1);
        @(negedge CLK);
        chk("jalr_pulse", {63'd0, jalr_redirect_vaild}, 64'd1);
        @(negedge CLK);
        chk("jalr_pulse_end", {63'd0, jalr_redirect_vaild}, 64'd0);
        idle(1);

        // Wrap cases
        issue(1'b1, 1'b0, 7'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0);
        issue(1'b0, 1'b1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h40, 64'd1, 1'b0);
        idle(3);

        // Malformed ops and rd0 = 0
        issue(1'b0, 1'b0, 7'd0, 64'h10, 64'h300, 64'h4, 1'b1);
        issue(1'b1, 1'b1, 7'd127, 64'h5000, 64'h600, 64'h3, 1'b0);
        idle(3);

        // Back-pressure: second op lands in the skid entry
        jal_writeback_ready = 1'b0;
        issue(1'b1, 1'b0, 7'd11, 64'd0, 64'hA000, 64'd0, 1'b0);
        issue(1'b1, 1'b0, 7'd12, 64'd0, 64'hB000, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_ready_low", {63'd0, jal_execute_ready}, 64'd0);
            chk("bp_hold_valid", {63'd0, jal_writeback_vaild}, 64'd1);
            chk("bp_hold_res", jal_res, 64'hA004);
            chk("bp_hold_rd0", {57'd0, jal_rd0}, 64'd11);
        end
        @(posedge CLK);
        #1 jal_writeback_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("bp_second_res", jal_res, 64'hB002);
        chk("bp_ready_back", {63'd0, jal_execute_ready}, 64'd1);
        @(posedge CLK);
        #1;
        chk("bp_drained", 64'(wb_q.size()), 64'd0);
        idle(1);

        // Flush with OUT, SKID and a redirect all pending
        jal_writeback_ready = 1'b0;
        issue(1'b1, 1'b0, 7'd3, 64'd0, 64'h4000, 64'd0, 1'b0);
        issue(1'b0, 1'b1, 7'd4, 64'h8000, 64'h4100, 64'h20, 1'b0);
        flush = 1'b1;
        @(negedge CLK);
        chk("flush_ready", {63'd0, jal_execute_ready}, 64'd0);
        @(posedge CLK);
        #1;
        flush = 1'b0;
        wb_q.delete();
        @(negedge CLK);
        chk("flush_wbv", {63'd0, jal_writeback_vaild}, 64'd0);
        chk("flush_rdv", {63'd0, jalr_redirect_vaild}, 64'd0);
        chk("flush_ready_back", {63'd0, jal_execute_ready}, 64'd1);
        @(posedge CLK);
        #1 jal_writeback_ready = 1'b1;
        idle(3);

        // Asynchronous reset during a stall
        jal_writeback_ready = 1'b0;
        issue(1'b1, 1'b0, 7'd20, 64'd0, 64'hC000, 64'd0, 1'b0);
        issue(1'b0, 1'b1, 7'd21, 64'h9000, 64'hC100, 64'h8, 1'b0);
        #2 RSTn = 1'b0;
        #1;
        check_reset_outputs("arst");
        wb_q.delete();
        rd_q.delete();
        jal_writeback_ready = 1'b1;
        @(posedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        chk("arst_wbv_after", {63'd0, jal_writeback_vaild}, 64'd0);
        @(posedge CLK);
        #1;
        issue(1'b1, 1'b0, 7'd1, 64'd0, 64'h8000_0000, 64'd0, 1'b0);
        @(negedge CLK);
        chk("arst_jal_valid", {63'd0, jal_writeback_vaild}, 64'd1);
        chk("arst_jal_res", jal_res, 64'h8000_0004);
        idle(4);

        chk("end_wb_q", 64'(wb_q.size()), 64'd0);
        chk("end_rd_q", 64'(rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jal_execute.md
Name: jal_execute

Overview:
- Execute-side consumer of the jal/jalr issue queue. Takes one issued jump per handshake on jal_execute_vaild/jal_execute_ready.
- Computes the link value, plus the jump target for jalr.
- Presents the result to the writeback arbiter through a registered, back-pressurable output with a one-entry skid buffer.
- Raises a one-cycle redirect pulse toward fetch when a jalr resolves.

Parameters:
- RNBIT, 2, rename bits per architectural register; physical index width = 5+RNBIT
- DW, 64, data/address width
- INFO_W, 2+(5+RNBIT)+3*DW+1, width of jal_execute_info

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- jal_execute_vaild  in  1  issue has a jump for execute
- jal_execute_ready  out  1  execute accepts this cycle
- jal_execute_info  in  INFO_W  packed MSB→LSB: {rv64i_jal, rv64i_jalr, rd0_index[5+RNBIT], src1[DW], pc[DW], imm[DW], is_rvc}
- jal_writeback_vaild  out  1  result valid toward writeback
- jal_writeback_ready  in  1  writeback accepts
- jal_res  out  DW  link value
- jal_rd0  out  5+RNBIT  destination physical index
- jalr_redirect_vaild  out  1  one-cycle jalr resolution pulse
- jalr_redirect_pc  out  DW  resolved jalr target
- flush  in  1  pipeline flush (mispredict/exception)

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RSTn is asynchronous and active-low.
  - On reset: jal_writeback_vaild=0, jalr_redirect_vaild=0, skid entry invalid, jal_res=0, jal_rd0=0, jalr_redirect_pc=0.
- Handshake:
  - Accept occurs when jal_execute_vaild & jal_execute_ready.
  - jal_execute_ready = ~skid_valid & ~flush. It is registered-state derived only, with no combinational path from jal_writeback_ready.
  - Issue pops on the same condition, so ready must not depend on jal_execute_vaild.
- Arithmetic (combinational on accept):
  - link = pc + (is_rvc ? 2 : 4), modulo 2^DW (wraps silently).
  - target = (src1 + imm) & ~1, modulo 2^DW.
  - When rv64i_jal=1, target is not used (jal is resolved in fetch).
- Latency:
  - An accepted op appears on jal_writeback_vaild/jal_res/jal_rd0 the next cycle when the output register is free or draining.
  - Otherwise the op goes into the skid entry.
- Output register (OUT) and skid entry (SKID):
  - OUT free, or OUT draining (vaild & ready): the accepted op loads OUT. If SKID is valid, SKID loads OUT first and the accepted op is impossible, since ready=0.
  - OUT held (vaild & ~ready) while an accept occurs: the op goes to SKID, and ready drops the next cycle.
  - OUT drains while SKID is valid: SKID→OUT, SKID is cleared, and ready returns the following cycle.
  - OUT data must stay stable while vaild & ~ready.
- Redirect:
  - jalr_redirect_vaild=1 for exactly one cycle, the cycle after accepting an op with rv64i_jalr=1.
  - jalr_redirect_pc = target.
  - The redirect does not wait for writeback.
  - Not asserted for jal.
- Flush:
  - flush=1 clears OUT valid, SKID valid, and the pending redirect in the next edge.
  - No accept occurs in a flush cycle, since ready=0.
  - Flush has priority over every simultaneous load.
- Malformed ops: rv64i_jal=rv64i_jalr=0, or both set.
  - Link is still written back.
  - Redirect is governed by rv64i_jalr alone.
- rd0 = 0 (architectural x0): written back unchanged; the regfile discards the write.
- Reset mid-stall: all state drops asynchronously; no result is replayed.

Decomposition:
- Shared package holds:
  - RNBIT and DW.
  - Field offsets/widths of the jal info bundle, shared with the issue side.
  - The RVC/normal PC increment constants (2, 4).
- One natural sub-module: pipe_skid, a generic 2-entry (output + skid) valid/ready register parameterised by width. It carries {rd0, link}. Redirect logic stays in jal_execute.

Test Plan:
- Single jal: pc=0x8000_0000, is_rvc=0, rd0=1, writeback_ready=1 → next cycle jal_writeback_vaild=1, jal_res=0x8000_0004, jal_rd0=1; no redirect.
- Compressed jalr: pc=0x1000, is_rvc=1, src1=0x2001, imm=0x10 → redirect pulse 1 cycle with pc=0x2010, jal_res=0x1002.
- Back-pressure: writeback_ready=0, issue 2 ops back-to-back → second lands in SKID, ready=0 from cycle 2. Release ready → results emerge in order, 1 per cycle, data stable while stalled.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, is_rvc=0 → jal_res=0. jalr with src1=0xFFFF_FFFF_FFFF_FFFF, imm=1 → target=0.
- Flush with OUT and SKID both valid and a jalr redirect pending → next cycle all valids 0, no redirect pulse, ready=1 the cycle after flush deasserts.
- Async reset asserted mid-stall (between edges) → outputs 0 immediately; after release, the first accepted op behaves as in test 1.
